// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a synchronous single-port data RAM.
// One request per handshake; registered RAM strobes; fixed read latency RD_LAT.
module mem_access_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [11:0]       controll,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              resp_valid,
    output logic [DATA_W-1:0] memout,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t            state;
    logic              read_reg;
    logic [1:0]        wait_cnt;
    logic              sel_alt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              unused_ctrl;

    // Bit 10 picks the indirect (address2/data2) pair for both read and write.
    assign sel_alt     = controll[10];
    assign sel_addr    = sel_alt ? address2 : address1;
    assign sel_data    = sel_alt ? data2 : data1;
    assign unused_ctrl = ^{controll[11], controll[7:0]};

    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            read_reg   <= 1'b0;
            wait_cnt   <= 2'd0;
            resp_valid <= 1'b0;
            memout     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        read_reg <= controll[9];
                        if (controll[8]) begin
                            state     <= WR;
                            mem_we    <= 1'b1;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_data;
                        end else if (controll[9]) begin
                            state    <= RD;
                            mem_re   <= 1'b1;
                            mem_addr <= sel_addr;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                WR: begin
                    // mem_addr still holds the selected address for the follow-on read
                    if (read_reg) begin
                        state  <= RD;
                        mem_re <= 1'b1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RD: begin
                    state    <= RWAIT;
                    wait_cnt <= WAIT_INIT;
                end
                RWAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        memout     <= mem_rdata;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two units (RD_LAT=1 and RD_LAT=3) each with a RAM model,
// directed vector table, reset/hold sequences and random requests vs a reference model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        ram_clr;
    logic [11:0] controll;
    logic [11:0] address1;
    logic [11:0] address2;
    logic [15:0] data1;
    logic [15:0] data2;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [15:0] memout     [2];
    logic        busy       [2];
    logic [11:0] mem_addr   [2];
    logic [15:0] mem_wdata  [2];
    logic        mem_we     [2];
    logic        mem_re     [2];
    logic [15:0] mem_rdata  [2];

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        localparam int L = (gi == 0) ? 1 : 3;
        logic [15:0] ram  [4096];
        logic [15:0] pipe [4];

        // RAM model: DEAD marks a slot that was not driven by a read strobe
        always @(posedge clk) begin
            if (ram_clr) begin
                for (int i = 0; i < 4096; i++) ram[i] <= 16'h0000;
            end else if (mem_we[gi]) begin
                ram[mem_addr[gi]] <= mem_wdata[gi];
            end
            pipe[0] <= mem_re[gi] ? ram[mem_addr[gi]] : 16'hDEAD;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[gi] = pipe[L-1];

        mem_access_unit #(.ADDR_W(12), .DATA_W(16), .RD_LAT(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .controll  (controll),
            .address1  (address1),
            .address2  (address2),
            .data1     (data1),
            .data2     (data2),
            .resp_valid(resp_valid[gi]),
            .memout    (memout[gi]),
            .busy      (busy[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_we    (mem_we[gi]),
            .mem_re    (mem_re[gi]),
            .mem_rdata (mem_rdata[gi])
        );
    end

    // Reference model: memory contents and last read value per unit
    logic [15:0] mdl_mem  [2][4096];
    logic [15:0] mdl_last [2];

    typedef struct {
        int          u;
        logic [11:0] ctrl;
        logic [11:0] a1;
        logic [11:0] a2;
        logic [15:0] d1;
        logic [15:0] d2;
        int          e_resp;
        int          e_we;
        int          e_re;
        logic [11:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_memout;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mdl_predict(input int u, input logic [11:0] ctrl,
                               input logic [11:0] a1, input logic [11:0] a2,
                               input logic [15:0] d1, input logic [15:0] d2,
                               output int e_resp, output int e_we, output int e_re,
                               output logic [11:0] e_addr, output logic [15:0] e_wdata,
                               output logic [15:0] e_memout);
        int lat;
        bit wr, rd;
        lat      = (u == 0) ? 1 : 3;
        wr       = ctrl[8];
        rd       = ctrl[9];
        e_addr   = ctrl[10] ? a2 : a1;
        e_wdata  = ctrl[10] ? d2 : d1;
        e_we     = wr ? 1 : 0;
        e_re     = rd ? (wr ? 2 : 1) : 0;
        if (wr && rd)  e_resp = 3 + lat;
        else if (rd)   e_resp = 2 + lat;
        else if (wr)   e_resp = 2;
        else           e_resp = 1;
        if (rd)        e_memout = wr ? e_wdata : mdl_mem[u][e_addr];
        else           e_memout = mdl_last[u];
    endtask

    task automatic mdl_apply(input int u, input logic [11:0] ctrl,
                             input logic [11:0] a1, input logic [11:0] a2,
                             input logic [15:0] d1, input logic [15:0] d2);
        logic [11:0] a;
        a = ctrl[10] ? a2 : a1;
        if (ctrl[8]) mdl_mem[u][a] = ctrl[10] ? d2 : d1;
        if (ctrl[9]) mdl_last[u] = mdl_mem[u][a];
    endtask

    task automatic check_reset_vals(input int u);
        chk("rst_req_ready", 32'(req_ready[u]), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
        chk("rst_busy", 32'(busy[u]), 32'd0);
        chk("rst_memout", 32'(memout[u]), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr[u]), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata[u]), 32'd0);
        chk("rst_mem_we", 32'(mem_we[u]), 32'd0);
        chk("rst_mem_re", 32'(mem_re[u]), 32'd0);
    endtask

    task automatic do_req(input int u, input logic [11:0] ctrl,
                          input logic [11:0] a1, input logic [11:0] a2,
                          input logic [15:0] d1, input logic [15:0] d2,
                          input int e_resp, input int e_we, input int e_re,
                          input logic [11:0] e_addr, input logic [15:0] e_wdata,
                          input logic [15:0] e_memout);
        int guard;
        logic [15:0] mo_before;
        @(negedge clk);
        guard = 0;
        while (!req_ready[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait_timeout", 32'(guard < 50), 32'd1);
        mo_before    = memout[u];
        controll     = ctrl;
        address1     = a1;
        address2     = a2;
        data1        = d1;
        data2        = d2;
        req_valid[u] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
        // inputs are don't-care once accepted
        controll = 12'($urandom);
        address1 = 12'($urandom);
        address2 = 12'($urandom);
        data1    = 16'($urandom);
        data2    = 16'($urandom);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("resp_valid", 32'(resp_valid[u]), 32'(k == e_resp));
            chk("mem_we", 32'(mem_we[u]), 32'(k == e_we));
            chk("mem_re", 32'(mem_re[u]), 32'(k == e_re));
            chk("busy", 32'(busy[u]), 32'(k <= e_resp));
            chk("req_ready", 32'(req_ready[u]), 32'(k > e_resp));
            if (k == e_we) begin
                chk("we_addr", 32'(mem_addr[u]), 32'(e_addr));
                chk("we_wdata", 32'(mem_wdata[u]), 32'(e_wdata));
            end
            if (k == e_re) chk("re_addr", 32'(mem_addr[u]), 32'(e_addr));
            if (k < e_resp) chk("memout_hold", 32'(memout[u]), 32'(mo_before));
            else            chk("memout", 32'(memout[u]), 32'(e_memout));
        end
        mdl_apply(u, ctrl, a1, a2, d1, d2);
        $display("[TB] unit%0d ctrl=%h addr=%h resp@c%0d memout=%h (exp %h)",
                 u, ctrl, e_addr, e_resp, memout[u], e_memout);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_resp, e_we, e_re;
        logic [11:0] e_addr, c, a1, a2;
        logic [15:0] e_wdata, e_memout, d1, d2;
        int n_acc, n_resp, n_bad;

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4096; i++) mdl_mem[u][i] = 16'h0000;
            mdl_last[u]  = 16'h0000;
            req_valid[u] = 1'b0;
        end
        controll = '0; address1 = '0; address2 = '0; data1 = '0; data2 = '0;
        ram_clr  = 1'b1;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        for (int u = 0; u < 2; u++) check_reset_vals(u);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release0", 32'(req_ready[0]), 32'd1);
        chk("ready_after_release1", 32'(req_ready[1]), 32'd1);

        // Prime RAM[0x005], then reset in the middle of a read of it
        do_req(0, 12'h100, 12'h005, 12'h777, 16'h0C0D, 16'h1111, 2, 1, 0, 12'h005, 16'h0C0D, 16'h0000);
        @(negedge clk);
        controll = 12'h200; address1 = 12'h005; address2 = 12'h777;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rd_before_reset", 32'(mem_re[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        mdl_last[0] = 16'h0000;
        mdl_last[1] = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            chk("no_resp_in_reset", 32'(resp_valid[0]), 32'd0);
        end
        rst_n = 1'b1;
        do_req(0, 12'h200, 12'h005, 12'h777, 16'h0, 16'h0, 3, 0, 1, 12'h005, 16'h0, 16'h0C0D);

        tbl[0]  = '{0, 12'h100, 12'h012, 12'h0AB, 16'hBEEF, 16'h1111, 2, 1, 0, 12'h012, 16'hBEEF, 16'h0C0D};
        tbl[1]  = '{0, 12'h200, 12'h012, 12'h0AB, 16'h0000, 16'h0000, 3, 0, 1, 12'h012, 16'h0000, 16'hBEEF};
        tbl[2]  = '{0, 12'h500, 12'h034, 12'hFFF, 16'h2222, 16'h1234, 2, 1, 0, 12'hFFF, 16'h1234, 16'hBEEF};
        tbl[3]  = '{0, 12'h700, 12'h0B0, 12'h0A0, 16'h3333, 16'h55AA, 4, 1, 2, 12'h0A0, 16'h55AA, 16'h55AA};
        tbl[4]  = '{0, 12'h000, 12'h0C0, 12'h0D0, 16'h4444, 16'h5555, 1, 0, 0, 12'h000, 16'h0000, 16'h55AA};
        tbl[5]  = '{0, 12'h8FF, 12'h0C0, 12'h0D0, 16'h4444, 16'h5555, 1, 0, 0, 12'h000, 16'h0000, 16'h55AA};
        tbl[6]  = '{1, 12'h500, 12'h001, 12'hFFF, 16'h4444, 16'h1234, 2, 1, 0, 12'hFFF, 16'h1234, 16'h0000};
        tbl[7]  = '{1, 12'h600, 12'h002, 12'hFFF, 16'h0000, 16'h0000, 5, 0, 1, 12'hFFF, 16'h0000, 16'h1234};
        tbl[8]  = '{1, 12'h300, 12'h345, 12'h0A0, 16'hA5A5, 16'h5A5A, 6, 1, 2, 12'h345, 16'hA5A5, 16'hA5A5};
        tbl[9]  = '{1, 12'h2FF, 12'hFFF, 12'h345, 16'h0000, 16'h0000, 5, 0, 1, 12'hFFF, 16'h0000, 16'h1234};
        tbl[10] = '{0, 12'h600, 12'h0A0, 12'hFFF, 16'h0000, 16'h0000, 3, 0, 1, 12'hFFF, 16'h0000, 16'h1234};
        for (int i = 0; i < 11; i++) begin
            do_req(tbl[i].u, tbl[i].ctrl, tbl[i].a1, tbl[i].a2, tbl[i].d1, tbl[i].d2,
                   tbl[i].e_resp, tbl[i].e_we, tbl[i].e_re, tbl[i].e_addr,
                   tbl[i].e_wdata, tbl[i].e_memout);
        end

        // No-op with req_valid held high: one accept per IDLE visit
        @(negedge clk);
        controll = 12'h000;
        req_valid[0] = 1'b1;
        n_acc = 0; n_resp = 0; n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[0]) n_acc++;
            if (resp_valid[0]) n_resp++;
            if ((req_ready[0] && busy[0]) || mem_we[0] || mem_re[0]) n_bad++;
            if (i < 19) @(negedge clk);
        end
        req_valid[0] = 1'b0;
        chk("hold_accepts", 32'(n_acc), 32'd10);
        chk("hold_resps", 32'(n_resp), 32'd10);
        chk("hold_violations", 32'(n_bad), 32'd0);
        chk("hold_memout", 32'(memout[0]), 32'(mdl_last[0]));
        @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 40; n++) begin
                c  = 12'($urandom);
                a1 = 12'($urandom_range(0, 15));
                a2 = 12'hFF0 | 12'($urandom_range(0, 15));
                d1 = 16'($urandom);
                d2 = 16'($urandom);
                mdl_predict(u, c, a1, a2, d1, d2, e_resp, e_we, e_re, e_addr, e_wdata, e_memout);
                do_req(u, c, a1, a2, d1, d2, e_resp, e_we, e_re, e_addr, e_wdata, e_memout);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencing front-end placed directly upstream of the TOY data memory. It takes one load/store request per handshake from the single-cycle datapath, using the same control encoding as the data memory path. It then drives a synchronous single-port RAM with registered strobes and returns read data with a one-cycle response pulse. It lets the data memory be built as a real clocked RAM with a fixed read latency, instead of as a level-sensitive array.

## Interface
- ADDR_W, 12, address width (instruction address field and A[11:0]).
- DATA_W, 16, data word width.
- RD_LAT, 1, RAM read latency in cycles from the `mem_re` sample edge to valid `mem_rdata`; legal values are 1..4.

- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- controll  in  12  control word:
  - [11:10] source select; only bit [10] is significant.
  - [9] read.
  - [8] write.
  - [7:0] ignored.
- address1  in  ADDR_W  direct address (ins[11:0]).
- address2  in  ADDR_W  indirect address (A[11:0]).
- data1  in  DATA_W  store data paired with address1.
- data2  in  DATA_W  store data paired with address2.
- resp_valid  out  1  one-cycle pulse marking completion of an accepted request.
- memout  out  DATA_W  last read data; holds its value between reads.
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_we  out  1  RAM write strobe, registered.
- mem_re  out  1  RAM read strobe, registered.
- mem_rdata  in  DATA_W  RAM read data.

## Operation
- States: IDLE, WR, RD, RWAIT, RESP.
- Accept: `req_valid & req_ready` at a rising edge. At that edge, latch controll[10:8], both addresses and both data words. Inputs are don't-care after acceptance.
- Select rule:
  - controll[10]=0: address1, with data1 for a write.
  - controll[10]=1: address2, with data2 for a write.
  - Read and write use the same select.
- Transitions out of IDLE on accept:
  - write=1 → WR.
  - write=0, read=1 → RD.
  - Neither bit set → RESP (no-op).
- WR: one cycle with mem_we=1, mem_addr and mem_wdata per the select rule. Next state is RD if read=1, else RESP.
- Read+write in one request: the write is issued first, so the read returns the newly written word.
- RD: one cycle with mem_re=1 and mem_addr per the select rule. Next state is RWAIT.
- RWAIT: wait counter loaded with RD_LAT-1 on entry.
  - Counter nonzero: decrement each cycle and stay.
  - Counter zero: capture mem_rdata into memout at that edge, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- memout changes only on a read capture or reset. Write-only and no-op requests leave it unchanged.
- mem_we and mem_re are never high in the same cycle. Each is high for exactly one cycle per access.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE.
  - req_ready=1 once rst_n is released; req_ready=0 while rst_n is low.
  - resp_valid=0, busy=0, memout=0.
  - mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
  - wait counter=0.
- Cycle numbering: c0 is the cycle in which the accept is sampled at its closing edge.
- Latency to the resp_valid cycle:
  - No-op: c1.
  - Write: mem_we in c1; resp in c2.
  - Read: mem_re in c1; memout valid and resp in c2+RD_LAT.
  - Read+write: mem_we in c1, mem_re in c2, resp in c3+RD_LAT.
- req_ready is low from c1 through the RESP cycle. The next accept can occur no earlier than the cycle after RESP, so there is no overlap between requests.
- memout is valid in the resp_valid cycle and stays stable until the next read capture.
- Reset mid-operation:
  - The in-flight request is dropped with no resp_valid.
  - Any asserted mem_we or mem_re drops immediately.
  - The first post-reset request behaves as from cold.
- req_valid held high during busy: ignored, no side effects.

## Test plan
- Reset with RD_LAT=1, then drive rst_n low mid-RD → all outputs 0, no resp_valid; a read of 0x005 after release behaves normally.
- Store controll=0x100, address1=0x012, data1=0xBEEF → mem_we=1 in c1 only, mem_addr=0x012, mem_wdata=0xBEEF; resp_valid in c2; memout unchanged.
- Load indirect controll=0x600, address2=0xFFF, RAM[0xFFF]=0x1234, RD_LAT=3 → mem_re in c1, memout=0x1234 and resp_valid in c5.
- Read+write controll=0x700, address2=0x0A0, data2=0x55AA, RD_LAT=1 → mem_we in c1, mem_re in c2, memout=0x55AA with resp_valid in c4.
- No-op controll=0x000 → resp_valid in c1, no mem_we or mem_re; req_valid held high throughout → exactly one accept per IDLE visit, and req_ready=0 whenever busy=1.
